move_entry: RTL and testbench

Upstream input stage of the Triangles vs Circles game. It conditions the three raw push-buttons, assembles the bit-serial 8-bit coordinate entered by the player, and range-checks it against the board. It then presents one validated move (x, y) to the game controller over a valid/ready handshake. It also exposes the partial entry buffer so the display stage can echo the bits typed so far.

---
 rtl/game_pkg.sv | 18 +
 rtl/button_conditioner.sv | 63 ++++++
 rtl/move_entry.sv | 146 ++++++++++++++
 tb/tb_move_entry.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Triangles vs Circles game: board defaults, move payload, entry FSM states.
package game_pkg;

  localparam int unsigned DEFAULT_BOARD_SIZE = 10;
  localparam int unsigned DEFAULT_COORD_W    = 4;

  typedef struct packed {
    logic [DEFAULT_COORD_W-1:0] x;
    logic [DEFAULT_COORD_W-1:0] y;
  } move_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_PENDING = 2'd2
  } entry_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-flop synchronizer, optional debounce, rising-edge detect.
// Debounce filter is built only when MOVE_ENTRY_DEBOUNCE_EN is defined.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Accept the new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^32'(DEBOUNCE_CYCLES);
  assign level      = sync_2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/move_entry.sv
// Player move entry: conditions three buttons, assembles a bit-serial coordinate pair,
// range-checks it and offers it over valid/ready. Debounce enabled by MOVE_ENTRY_DEBOUNCE_EN.
module move_entry
  import game_pkg::*;
#(
  parameter int unsigned BOARD_SIZE      = DEFAULT_BOARD_SIZE,
  parameter int unsigned COORD_W         = DEFAULT_COORD_W,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 logic_0_button,
  input  logic                 logic_1_button,
  input  logic                 activity_button,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic [COORD_W-1:0]   move_x,
  output logic [COORD_W-1:0]   move_y,
  output logic [2*COORD_W-1:0] entry_buf,
  output logic [3:0]           bit_count,
  output logic                 entry_error
);

  localparam int unsigned ENTRY_W = 2 * COORD_W;
  localparam logic [3:0] COUNT_FULL = 4'(ENTRY_W);
  localparam logic [COORD_W:0] COORD_LIMIT = (COORD_W + 1)'(BOARD_SIZE);

  localparam logic [1:0] COLLECT = 2'(ST_COLLECT);
  localparam logic [1:0] FULL    = 2'(ST_FULL);
  localparam logic [1:0] PENDING = 2'(ST_PENDING);

  logic p0;
  logic p1;
  logic pa;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_0 (
    .clk   (clk),
    .reset (reset),
    .raw   (logic_0_button),
    .press (p0)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_1 (
    .clk   (clk),
    .reset (reset),
    .raw   (logic_1_button),
    .press (p1)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clk   (clk),
    .reset (reset),
    .raw   (activity_button),
    .press (pa)
  );

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [ENTRY_W-1:0] buf_n;
  logic [3:0]         count_n;
  logic [COORD_W-1:0] x_n;
  logic [COORD_W-1:0] y_n;
  logic               valid_n;
  logic               error_n;

  logic [COORD_W-1:0] entry_x;
  logic [COORD_W-1:0] entry_y;
  logic               coords_ok;

  assign entry_x   = entry_buf[ENTRY_W-1 -: COORD_W];
  assign entry_y   = entry_buf[COORD_W-1:0];
  assign coords_ok = ({1'b0, entry_x} < COORD_LIMIT) && ({1'b0, entry_y} < COORD_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      entry_buf   <= '0;
      bit_count   <= '0;
      move_x      <= '0;
      move_y      <= '0;
      move_valid  <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      entry_buf   <= buf_n;
      bit_count   <= count_n;
      move_x      <= x_n;
      move_y      <= y_n;
      move_valid  <= valid_n;
      entry_error <= error_n;
    end
  end

  // Submit has priority over bit presses; simultaneous 0 and 1 presses cancel out.
  always_comb begin
    state_n = state;
    buf_n   = entry_buf;
    count_n = bit_count;
    x_n     = move_x;
    y_n     = move_y;
    valid_n = move_valid;
    error_n = 1'b0;
    case (state)
      COLLECT: begin
        if (pa) begin
          error_n = 1'b1;
          buf_n   = '0;
          count_n = '0;
        end else if (p0 ^ p1) begin
          buf_n   = {entry_buf[ENTRY_W-2:0], p1};
          count_n = bit_count + 4'd1;
          if (count_n == COUNT_FULL) begin
            state_n = FULL;
          end
        end
      end
      FULL: begin
        if (pa) begin
          if (coords_ok) begin
            x_n     = entry_x;
            y_n     = entry_y;
            valid_n = 1'b1;
            state_n = PENDING;
          end else begin
            error_n = 1'b1;
            buf_n   = '0;
            count_n = '0;
            state_n = COLLECT;
          end
        end
      end
      PENDING: begin
        if (move_valid && move_ready) begin
          valid_n = 1'b0;
          buf_n   = '0;
          count_n = '0;
          state_n = COLLECT;
        end
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_move_entry.sv
// Directed self-checking bench for move_entry; runs in either debounce build (DEBOUNCE_CYCLES=4).
module tb_move_entry;

  localparam int unsigned DEB = 4;
`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int H = LAT + 2;

  localparam logic [2:0] B0 = 3'b001;
  localparam logic [2:0] B1 = 3'b010;
  localparam logic [2:0] PA = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       logic_0_button = 1'b0;
  logic       logic_1_button = 1'b0;
  logic       activity_button = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [3:0] move_x;
  logic [3:0] move_y;
  logic [7:0] entry_buf;
  logic [3:0] bit_count;
  logic       entry_error;

  int errors = 0;
  int checks = 0;
  int err_seen;
  int val_seen;
  logic [3:0] cap_x;
  logic [3:0] cap_y;

  move_entry #(
    .BOARD_SIZE      (10),
    .COORD_W         (4),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .logic_0_button  (logic_0_button),
    .logic_1_button  (logic_1_button),
    .activity_button (activity_button),
    .move_valid      (move_valid),
    .move_ready      (move_ready),
    .move_x          (move_x),
    .move_y          (move_y),
    .entry_buf       (entry_buf),
    .bit_count       (bit_count),
    .entry_error     (entry_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    if (entry_error) err_seen++;
    if (move_valid) begin
      val_seen++;
      cap_x = move_x;
      cap_y = move_y;
    end
  endtask

  task automatic clear_seen();
    err_seen = 0;
    val_seen = 0;
    cap_x    = 4'hF;
    cap_y    = 4'hF;
  endtask

  // Hold the selected buttons for H cycles, then release for H cycles.
  task automatic press(input logic [2:0] which);
    logic_0_button  = which[0];
    logic_1_button  = which[1];
    activity_button = which[2];
    repeat (H) begin tick(); sample(); end
    logic_0_button  = 1'b0;
    logic_1_button  = 1'b0;
    activity_button = 1'b0;
    repeat (H) begin tick(); sample(); end
  endtask

  task automatic enter_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) press(b[i] ? B1 : B0);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({move_valid, move_x, move_y, entry_buf, bit_count, entry_error} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values got v=%b x=%0d y=%0d buf=%h cnt=%0d err=%b want all 0",
               move_valid, move_x, move_y, entry_buf, bit_count, entry_error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_press_latency();
    logic_1_button = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (bit_count !== 4'd0) begin
      errors++;
      $display("FAIL latency_early got cnt=%0d want 0", bit_count);
    end
    tick();
    checks++;
    if (bit_count !== 4'd1 || entry_buf !== 8'h01) begin
      errors++;
      $display("FAIL latency_on_time got cnt=%0d buf=%h want 1/01", bit_count, entry_buf);
    end
    repeat (H) tick();
    logic_1_button = 1'b0;
    repeat (H) tick();
    checks++;
    if (bit_count !== 4'd1) begin
      errors++;
      $display("FAIL hold_single_pulse got cnt=%0d want 1", bit_count);
    end
    clear_seen();
    press(PA);
    checks++;
    if (err_seen !== 1 || bit_count !== 4'd0 || entry_buf !== 8'h00) begin
      errors++;
      $display("FAIL collect_submit got err=%0d cnt=%0d buf=%h want 1/0/00", err_seen, bit_count, entry_buf);
    end
  endtask

  task automatic test_valid_move();
    move_ready = 1'b1;
    clear_seen();
    enter_byte(8'h35);
    checks++;
    if (entry_buf !== 8'h35 || bit_count !== 4'd8) begin
      errors++;
      $display("FAIL full_entry got buf=%h cnt=%0d want 35/8", entry_buf, bit_count);
    end
    press(PA);
    checks++;
    if (val_seen !== 1 || err_seen !== 0 || cap_x !== 4'd3 || cap_y !== 4'd5) begin
      errors++;
      $display("FAIL valid_move got valid_cycles=%0d err=%0d x=%0d y=%0d want 1/0/3/5",
               val_seen, err_seen, cap_x, cap_y);
    end
    checks++;
    if (bit_count !== 4'd0 || entry_buf !== 8'h00 || move_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake got cnt=%0d buf=%h v=%b want 0/00/0", bit_count, entry_buf, move_valid);
    end
  endtask

  task automatic test_out_of_range();
    move_ready = 1'b1;
    clear_seen();
    enter_byte(8'hA2);
    press(PA);
    checks++;
    if (err_seen !== 1 || val_seen !== 0 || entry_buf !== 8'h00 || bit_count !== 4'd0) begin
      errors++;
      $display("FAIL x_out_of_range got err=%0d valid_cycles=%0d buf=%h cnt=%0d want 1/0/00/0",
               err_seen, val_seen, entry_buf, bit_count);
    end
    clear_seen();
    enter_byte(8'h9A);
    press(PA);
    checks++;
    if (err_seen !== 1 || val_seen !== 0 || entry_buf !== 8'h00) begin
      errors++;
      $display("FAIL y_out_of_range got err=%0d valid_cycles=%0d buf=%h want 1/0/00", err_seen, val_seen, entry_buf);
    end
  endtask

  task automatic test_partial_and_overflow();
    move_ready = 1'b1;
    press(B1); press(B0); press(B1); press(B1); press(B0);
    checks++;
    if (entry_buf !== 8'h16 || bit_count !== 4'd5) begin
      errors++;
      $display("FAIL partial_entry got buf=%h cnt=%0d want 16/5", entry_buf, bit_count);
    end
    clear_seen();
    press(PA);
    checks++;
    if (err_seen !== 1 || entry_buf !== 8'h00 || bit_count !== 4'd0) begin
      errors++;
      $display("FAIL partial_submit got err=%0d buf=%h cnt=%0d want 1/00/0", err_seen, entry_buf, bit_count);
    end
    press(B0 | B1);
    checks++;
    if (bit_count !== 4'd0) begin
      errors++;
      $display("FAIL both_bits_discarded got cnt=%0d want 0", bit_count);
    end
    clear_seen();
    press(PA | B1);
    checks++;
    if (err_seen !== 1 || bit_count !== 4'd0) begin
      errors++;
      $display("FAIL submit_priority got err=%0d cnt=%0d want 1/0", err_seen, bit_count);
    end
    enter_byte(8'h12);
    press(B1);
    press(B0);
    checks++;
    if (entry_buf !== 8'h12 || bit_count !== 4'd8) begin
      errors++;
      $display("FAIL ninth_press got buf=%h cnt=%0d want 12/8", entry_buf, bit_count);
    end
    clear_seen();
    press(PA);
    checks++;
    if (val_seen !== 1 || cap_x !== 4'd1 || cap_y !== 4'd2) begin
      errors++;
      $display("FAIL move_after_overflow got valid_cycles=%0d x=%0d y=%0d want 1/1/2", val_seen, cap_x, cap_y);
    end
  endtask

  task automatic test_pending_hold();
    int bad;
    move_ready = 1'b0;
    enter_byte(8'h47);
    press(PA);
    checks++;
    if (move_valid !== 1'b1 || move_x !== 4'd4 || move_y !== 4'd7) begin
      errors++;
      $display("FAIL pending_enter got v=%b x=%0d y=%0d want 1/4/7", move_valid, move_x, move_y);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      logic_0_button  = (i % 6) < 3;
      logic_1_button  = ((i + 2) % 7) < 3;
      activity_button = (i % 8) >= 4;
      tick();
      if (move_valid !== 1'b1 || move_x !== 4'd4 || move_y !== 4'd7) bad++;
    end
    logic_0_button  = 1'b0;
    logic_1_button  = 1'b0;
    activity_button = 1'b0;
    repeat (2 * H) begin
      tick();
      if (move_valid !== 1'b1 || move_x !== 4'd4 || move_y !== 4'd7) bad++;
    end
    checks++;
    if (bad !== 0 || entry_buf !== 8'h47 || bit_count !== 4'd8) begin
      errors++;
      $display("FAIL pending_stable got bad_cycles=%0d buf=%h cnt=%0d want 0/47/8", bad, entry_buf, bit_count);
    end
    move_ready = 1'b1;
    tick();
    checks++;
    if (move_valid !== 1'b0 || bit_count !== 4'd0 || entry_buf !== 8'h00) begin
      errors++;
      $display("FAIL handshake got v=%b cnt=%0d buf=%h want 0/0/00", move_valid, bit_count, entry_buf);
    end
    tick();
    checks++;
    if (move_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_while_idle got v=%b want 0", move_valid);
    end
    move_ready = 1'b0;
  endtask

  task automatic test_reset_pending();
    move_ready = 1'b0;
    enter_byte(8'h99);
    press(PA);
    checks++;
    if (move_valid !== 1'b1 || move_x !== 4'd9 || move_y !== 4'd9) begin
      errors++;
      $display("FAIL boundary_move got v=%b x=%0d y=%0d want 1/9/9", move_valid, move_x, move_y);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({move_valid, move_x, move_y, entry_buf, bit_count} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b x=%0d y=%0d buf=%h cnt=%0d want all 0",
               move_valid, move_x, move_y, entry_buf, bit_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_seen();
    press(PA);
    checks++;
    if (err_seen !== 1 || val_seen !== 0) begin
      errors++;
      $display("FAIL collect_after_reset got err=%0d valid_cycles=%0d want 1/0", err_seen, val_seen);
    end
    press(B1);
    checks++;
    if (bit_count !== 4'd1 || entry_buf !== 8'h01) begin
      errors++;
      $display("FAIL entry_after_reset got cnt=%0d buf=%h want 1/01", bit_count, entry_buf);
    end
  endtask

`ifdef MOVE_ENTRY_DEBOUNCE_EN
  task automatic test_debounce_glitch();
    logic_0_button = 1'b1;
    repeat (2) tick();
    logic_0_button = 1'b0;
    repeat (15) tick();
    checks++;
    if (bit_count !== 4'd1 || entry_buf !== 8'h01) begin
      errors++;
      $display("FAIL glitch_filtered got cnt=%0d buf=%h want 1/01", bit_count, entry_buf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press_latency();
    test_valid_move();
    test_out_of_range();
    test_partial_and_overflow();
    test_pending_hold();
    test_reset_pending();
`ifdef MOVE_ENTRY_DEBOUNCE_EN
    test_debounce_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
